// File: rtl/decodificador7seg.sv
// rtl/decodificador7seg.sv - 7-segment display bus receiver: glyphs back to an 8-bit value
// Optional error counter: DECODIF7SEG_CONT_ERROS_EN
module decodificador7seg #(
  parameter int ESTAVEL     = 1,
  parameter int BRANCO_ZERO = 0
) (
  input  logic        clock,
  input  logic        zera_as_n,
  input  logic [11:0] display,
  output logic [7:0]  numero,
  output logic        pronto,
  output logic        erro,
  output logic [7:0]  erros
);

  localparam logic [1:0] ESPERA_D0 = 2'd0;
  localparam logic [1:0] ESPERA_D1 = 2'd1;
  localparam logic [1:0] ESPERA_D2 = 2'd2;
  localparam logic [1:0] CALCULA   = 2'd3;
  localparam logic [3:0] EST       = 4'(ESTAVEL);

  logic [11:0] amostra_q, anterior_q;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  estado_q, estado_d;
  logic [3:0]  uni_q, uni_d, dez_q, dez_d, cen_q, cen_d;
  logic [7:0]  numero_q, numero_d;
  logic        pronto_q, pronto_d, erro_q, erro_d;

  logic        mudou, captura, ocioso, ilegal, glifo_ok, branco, digito_ok, erro_cap, calc;
  logic [1:0]  digito, base, esperado;
  logic [3:0]  bcd;
  logic [9:0]  valor;

  always_comb begin
    mudou   = (amostra_q != anterior_q);
    cnt_d   = mudou ? 4'd1 : ((cnt_q == EST) ? cnt_q : cnt_q + 4'd1);
    // Capture once per run: only on the cycle the run length first hits EST.
    captura = (cnt_d == EST) && (mudou || (cnt_q != EST));
  end

  always_comb begin
    ocioso = 1'b0;
    ilegal = 1'b0;
    digito = 2'd0;
    case (amostra_q[11:8])
      4'b1110: digito = 2'd0;
      4'b1101: digito = 2'd1;
      4'b1011: digito = 2'd2;
      4'b0111: digito = 2'd3;
      4'b1111: ocioso = 1'b1;
      default: ilegal = 1'b1;
    endcase
    glifo_ok = 1'b1;
    branco   = 1'b0;
    bcd      = 4'd0;
    case (amostra_q[6:0])
      7'h40: bcd = 4'd0;
      7'h79: bcd = 4'd1;
      7'h24: bcd = 4'd2;
      7'h30: bcd = 4'd3;
      7'h19: bcd = 4'd4;
      7'h12: bcd = 4'd5;
      7'h02: bcd = 4'd6;
      7'h78: bcd = 4'd7;
      7'h00: bcd = 4'd8;
      7'h10: bcd = 4'd9;
      7'h7F: branco = 1'b1;
      default: glifo_ok = 1'b0;
    endcase
  end

  always_comb begin
    calc      = (estado_q == CALCULA);
    base      = calc ? ESPERA_D0 : estado_q;
    esperado  = (base == ESPERA_D1) ? 2'd1 : 2'd2;
    digito_ok = glifo_ok && (!branco || ((digito != 2'd0) && (BRANCO_ZERO != 0)));
    estado_d  = base;
    uni_d     = uni_q;
    dez_d     = dez_q;
    cen_d     = cen_q;
    erro_cap  = 1'b0;
    if (captura && !ocioso) begin
      if (ilegal) begin
        erro_cap = 1'b1;
        estado_d = ESPERA_D0;
      end else if (digito == 2'd3) begin
        if (!branco) begin
          erro_cap = 1'b1;
          estado_d = ESPERA_D0;
        end
      end else if (base == ESPERA_D0) begin
        // While hunting for the ones digit, tens/hundreds are skipped silently.
        if (digito == 2'd0) begin
          if (glifo_ok && !branco) begin
            uni_d    = bcd;
            estado_d = ESPERA_D1;
          end else begin
            erro_cap = 1'b1;
          end
        end
      end else if ((digito == esperado) && digito_ok) begin
        if (base == ESPERA_D1) begin
          dez_d    = bcd;
          estado_d = ESPERA_D2;
        end else begin
          cen_d    = bcd;
          estado_d = CALCULA;
        end
      end else begin
        erro_cap = 1'b1;
        if ((digito == 2'd0) && glifo_ok && !branco) begin
          uni_d    = bcd;
          estado_d = ESPERA_D1;
        end else begin
          estado_d = ESPERA_D0;
        end
      end
    end
  end

  always_comb begin
    valor    = 10'(cen_q) * 10'd100 + 10'(dez_q) * 10'd10 + 10'(uni_q);
    pronto_d = calc && (valor <= 10'd255);
    // The CALCULA outcome owns the pulse slot; a coincident capture error is dropped.
    erro_d   = calc ? (valor > 10'd255) : erro_cap;
    numero_d = pronto_d ? valor[7:0] : numero_q;
  end

  always_ff @(posedge clock or negedge zera_as_n) begin
    if (!zera_as_n) begin
      amostra_q  <= 12'hFFF;
      anterior_q <= 12'hFFF;
      cnt_q      <= 4'd0;
      estado_q   <= ESPERA_D0;
      uni_q      <= 4'd0;
      dez_q      <= 4'd0;
      cen_q      <= 4'd0;
      numero_q   <= 8'd0;
      pronto_q   <= 1'b0;
      erro_q     <= 1'b0;
    end else begin
      amostra_q  <= display;
      anterior_q <= amostra_q;
      cnt_q      <= cnt_d;
      estado_q   <= estado_d;
      uni_q      <= uni_d;
      dez_q      <= dez_d;
      cen_q      <= cen_d;
      numero_q   <= numero_d;
      pronto_q   <= pronto_d;
      erro_q     <= erro_d;
    end
  end

`ifdef DECODIF7SEG_CONT_ERROS_EN
  logic [7:0] erros_q, erros_d;
  always_comb begin
    erros_d = (erro_d && (erros_q != 8'hFF)) ? erros_q + 8'd1 : erros_q;
  end
  always_ff @(posedge clock or negedge zera_as_n) begin
    if (!zera_as_n) erros_q <= 8'd0;
    else            erros_q <= erros_d;
  end
  assign erros = erros_q;
`else
  assign erros = 8'h00;
`endif

  assign numero = numero_q;
  assign pronto = pronto_q;
  assign erro   = erro_q;

endmodule

// File: tb/tb_decodificador7seg.sv
// tb/tb_decodificador7seg.sv - directed vector bench for decodificador7seg
// Three instances: ESTAVEL=1 (a), ESTAVEL=1 with blank-as-zero (b), ESTAVEL=4 (c)
module tb_decodificador7seg;

  logic        clock = 1'b0;
  logic        zera_as_n = 1'b0;
  logic [11:0] disp = 12'hFFF;
  logic [7:0]  num_a, num_b, num_c, es_a, es_b, es_c;
  logic        pr_a, pr_b, pr_c, er_a, er_b, er_c;

  int checks = 0;
  int errors = 0;
  int pa, ea, pb, eb, pc, ec;

  typedef struct {
    logic [11:0] d;
    logic        p;
    logic        e;
    logic [7:0]  n;
    int          ne;
  } vec_t;
  vec_t tab[$];

  always #5 clock = ~clock;

  decodificador7seg #(.ESTAVEL(1), .BRANCO_ZERO(0)) u_a (
    .clock(clock), .zera_as_n(zera_as_n), .display(disp),
    .numero(num_a), .pronto(pr_a), .erro(er_a), .erros(es_a));
  decodificador7seg #(.ESTAVEL(1), .BRANCO_ZERO(1)) u_b (
    .clock(clock), .zera_as_n(zera_as_n), .display(disp),
    .numero(num_b), .pronto(pr_b), .erro(er_b), .erros(es_b));
  decodificador7seg #(.ESTAVEL(4), .BRANCO_ZERO(0)) u_c (
    .clock(clock), .zera_as_n(zera_as_n), .display(disp),
    .numero(num_c), .pronto(pr_c), .erro(er_c), .erros(es_c));

  function automatic int exp_es(input int n);
`ifdef DECODIF7SEG_CONT_ERROS_EN
    return n;
`else
    return 0 * n;
`endif
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic add(input logic [11:0] d, input logic p, input logic e, input logic [7:0] n, input int ne);
    vec_t v;
    v.d = d; v.p = p; v.e = e; v.n = n; v.ne = ne;
    tab.push_back(v);
  endtask

  task automatic tick(input logic [11:0] d);
    @(negedge clock);
    disp = d;
    @(posedge clock);
    #1;
    pa += int'(pr_a); ea += int'(er_a);
    pb += int'(pr_b); eb += int'(er_b);
    pc += int'(pr_c); ec += int'(er_c);
    if (pr_a && er_a) chk("a_pronto_erro_exclusive", 1, 0);
  endtask

  task automatic run(input logic [11:0] d, input int n);
    for (int k = 0; k < n; k++) tick(d);
  endtask

  task automatic clr_counts();
    pa = 0; ea = 0; pb = 0; eb = 0; pc = 0; ec = 0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    disp = 12'hFFF;
    zera_as_n = 1'b0;
    @(negedge clock);
    zera_as_n = 1'b1;
  endtask

  initial begin
    add(12'hE30,0,0,  0,0); add(12'hD78,0,0,  0,0); add(12'hB79,0,0,  0,0); add(12'hE30,0,0,  0,0);
    add(12'hD78,1,0,173,0); add(12'hB79,0,0,173,0); add(12'hE30,0,0,173,0); add(12'hE12,1,0,173,0);
    add(12'hD12,0,1,173,1); add(12'hB24,0,0,173,1); add(12'hFFF,0,0,173,1); add(12'hFFF,1,0,255,1);
    add(12'hE10,0,0,255,1); add(12'hD10,0,0,255,1); add(12'hB10,0,0,255,1); add(12'hFFF,0,0,255,1);
    add(12'hFFF,0,1,255,2); add(12'hE30,0,0,255,2); add(12'hB79,0,0,255,2); add(12'hFFF,0,1,255,3);
    add(12'hFFF,0,0,255,3); add(12'hE30,0,0,255,3); add(12'hD78,0,0,255,3); add(12'hB79,0,0,255,3);
    add(12'hFFF,0,0,255,3); add(12'hFFF,1,0,173,3); add(12'hE55,0,0,173,3); add(12'h7FF,0,1,173,4);
    add(12'h740,0,0,173,4); add(12'hFFF,0,1,173,5); add(12'hC40,0,0,173,5); add(12'hFFF,0,1,173,6);
    add(12'hFFF,0,0,173,6);

    #1;
    chk("reset_numero", int'(num_a), 0);
    chk("reset_pronto", int'(pr_a), 0);
    chk("reset_erro",   int'(er_a), 0);
    chk("reset_erros",  int'(es_a), 0);
    do_reset();

    clr_counts();
    foreach (tab[i]) begin
      tick(tab[i].d);
      chk($sformatf("vec%0d_pronto", i), int'(pr_a), int'(tab[i].p));
      chk($sformatf("vec%0d_erro", i),   int'(er_a), int'(tab[i].e));
      chk($sformatf("vec%0d_numero", i), int'(num_a), int'(tab[i].n));
      chk($sformatf("vec%0d_erros", i),  int'(es_a), exp_es(tab[i].ne));
    end

    // Mid-frame asynchronous reset after tens captured
    tick(12'hE30); tick(12'hD78); tick(12'hFFF);
    #2 zera_as_n = 1'b0;
    #1;
    chk("async_numero", int'(num_a), 0);
    chk("async_pronto", int'(pr_a), 0);
    chk("async_erros",  int'(es_a), 0);
    @(negedge clock) zera_as_n = 1'b1;
    clr_counts();
    run(12'hB79, 3); run(12'hFFF, 3);
    chk("after_reset_no_pronto", pa, 0);
    chk("after_reset_no_erro", ea, 0);
    clr_counts();
    tick(12'hE30); tick(12'hD78); tick(12'hB79); run(12'hFFF, 3);
    chk("after_reset_frame_pronto", pa, 1);
    chk("after_reset_frame_numero", int'(num_a), 173);

    // Blank tens/hundreds: value 7
    do_reset();
    clr_counts();
    tick(12'hE78); tick(12'hD7F); tick(12'hB7F); run(12'hFFF, 4);
    chk("bz1_pronto", pb, 1);
    chk("bz1_erro", eb, 0);
    chk("bz1_numero", int'(num_b), 7);
    chk("bz0_erro", ea, 1);
    chk("bz0_pronto", pa, 0);
    chk("bz0_numero", int'(num_a), 0);

    // ESTAVEL=4 with a one-cycle glitch during ones
    do_reset();
    clr_counts();
    run(12'hE30, 2); run(12'hD00, 1); run(12'hE30, 4);
    run(12'hD78, 4); run(12'hB79, 4); run(12'hFFF, 4);
    chk("est4_pronto", pc, 1);
    chk("est4_erro", ec, 0);
    chk("est4_numero", int'(num_c), 173);
    clr_counts();
    run(12'hC40, 4); run(12'hFFF, 3);
    chk("est4_illegal_erro", ec, 1);
    chk("est4_illegal_erros", int'(es_c), exp_es(1));
    chk("est4_numero_held", int'(num_c), 173);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
